// File: rtl/instruction_fetch_if.sv
// Instruction-memory fetch bus: word request/address out, data/ready back.
// The fetch stage is the master; the memory is the slave.
interface instruction_fetch_if;
   logic        req;
   logic [31:0] addr;
   logic [31:0] rdata;
   logic        ready;

   modport master (output req, output addr, input rdata, input ready);
   modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, fetches words over the imem handshake, and drives the
// IF/ID register, with a one-entry hold buffer and redirects during a pending fetch.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       stall,
   input  logic                       flush,
   input  logic                       pcsrc,
   input  logic [31:0]                branch_target,
   instruction_fetch_if.master        imem,
   output logic [31:0]                if_id_instruction_out,
   output logic [31:0]                if_id_npc_out,
   output logic                       if_id_valid
);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] npc;
      logic        valid;
   } if_id_t;

   localparam if_id_t BUBBLE = '{instr: NOP, npc: 32'h0, valid: 1'b0};

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] target_q, target_d;
   if_id_t      if_id_q, if_id_d;
   // Low for the first cycle after reset so a late ready from an abandoned fetch is ignored.
   logic        started_q, started_d;

   logic        req;
   logic        resp;
   logic [31:0] pc_plus4;
   logic [31:0] target;

   assign req      = started_q && (state_q != HOLD);
   assign resp     = req && imem.ready;
   assign pc_plus4 = pc_q + 32'd4;
   assign target   = {branch_target[31:2], 2'b00};

   assign imem.req  = req;
   assign imem.addr = pc_q;

   assign if_id_instruction_out = if_id_q.instr;
   assign if_id_npc_out         = if_id_q.npc;
   assign if_id_valid           = if_id_q.valid;

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path can leave a latch behind.
      state_d   = state_q;
      pc_d      = pc_q;
      hold_d    = hold_q;
      target_d  = target_q;
      if_id_d   = if_id_q;
      started_d = 1'b1;

      unique case (state_q)
         FETCH: begin
            if (pcsrc) begin
               if_id_d = BUBBLE;
               if (resp || !req) begin
                  pc_d = target;
               end else begin
                  target_d = target;
                  state_d  = DRAIN;
               end
            end else if (flush) begin
               if_id_d = BUBBLE;
            end else if (stall) begin
               if (resp) begin
                  hold_d  = imem.rdata;
                  state_d = HOLD;
               end
            end else if (resp) begin
               if_id_d = '{instr: imem.rdata, npc: pc_plus4, valid: 1'b1};
               pc_d    = pc_plus4;
            end else begin
               if_id_d = BUBBLE;
            end
         end

         HOLD: begin
            if (pcsrc) begin
               pc_d    = target;
               if_id_d = BUBBLE;
               state_d = FETCH;
            end else if (flush) begin
               if_id_d = BUBBLE;
               state_d = FETCH;
            end else if (!stall) begin
               if_id_d = '{instr: hold_q, npc: pc_plus4, valid: 1'b1};
               pc_d    = pc_plus4;
               state_d = FETCH;
            end
         end

         DRAIN: begin
            // The old-address response is thrown away; the latest redirect wins.
            if_id_d = BUBBLE;
            if (pcsrc) begin
               target_d = target;
            end
            if (resp) begin
               pc_d    = pcsrc ? target : target_q;
               state_d = FETCH;
            end
         end

         default: state_d = FETCH;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         hold_q    <= 32'h0;
         target_q  <= 32'h0;
         if_id_q   <= BUBBLE;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         hold_q    <= hold_d;
         target_q  <= target_d;
         if_id_q   <= if_id_d;
         started_q <= started_d;
      end
   end

endmodule
